sysbus_arbiter: RTL

- Shares the single Sysbus master port between the instruction-fetch unit (port 0, F) and the load/store unit (port 1, D).
- Holds one transaction in flight at a time and grants round-robin between the two ports.
- Drives the bus request/ack handshake, serialises write data beats, and steers response beats back to the owning port.
- Sits between the Core pipeline front-end/memory stage and the Sysbus interface.

---
 rtl/sysbus_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 19 +
 rtl/sysbus_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - shared tag constants and state/port types for the sysbus arbiter
package sysbus_pkg;

    // Request tag layout: [12] = READ/WRITE, [11:8] = type, [7:0] = id
    localparam logic       TAG_READ   = 1'b1;
    localparam logic       TAG_WRITE  = 1'b0;
    localparam logic [3:0] TAG_MEMORY = 4'h1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
//
// Ports:
//   req_i   [1:0]  request vector, bit 0 = port F, bit 1 = port D
//   last_i         index of the port granted most recently
//   valid_o        at least one request is present
//   idx_o          index of the chosen port
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       idx_o
);

    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign valid_o = |req_i;
    assign idx_o   = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - shares the Sysbus master port between fetch (F) and load/store (D)
//
// Ports:
//   clk, reset                 bus clock, asynchronous active-low reset
//   f_req/f_addr               fetch line read request, f_gnt/f_rvalid/f_rlast responses
//   d_req/d_write/d_addr       data line request, d_wdata/d_wready write beat handshake
//   d_gnt/d_rvalid/d_rlast     data port responses
//   r_data                     response beat data shared by both ports
//   bus_reqcyc/req/reqtag/ack  Sysbus request channel
//   bus_respcyc/resp/resptag   Sysbus response channel, bus_respack acknowledge
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [DATA_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic              f_rlast,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic [DATA_W-1:0] r_data,
    output logic              bus_reqcyc,
    output logic [DATA_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    input  logic [TAG_W-1:0]  bus_resptag,
    output logic              bus_respack
);

    localparam int                CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_e        state_q, state_d;
    port_e             last_q, last_d;
    port_e             owner_q, owner_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Sticky protocol-error flags: stray/mis-tagged response, requester dropping early
    logic              resp_err_q, resp_err_d;
    logic              req_err_q, req_err_d;

    logic pick_valid, pick_idx;
    logic is_write, tag_match, last_beat, owner_req;
    logic unused_bits;

    rr_pick2 u_pick (
        .req_i   ({d_req, f_req}),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign is_write    = (tag_q[TAG_W-1] == TAG_WRITE);
    assign tag_match   = (bus_resptag[0] == owner_q);
    assign last_beat   = (cnt_q == LAST_BEAT);
    assign owner_req   = (owner_q == PORT_D) ? d_req : f_req;
    // Line offset bits and the upper resptag fields carry no meaning here
    assign unused_bits = ^{bus_resptag[TAG_W-1:1], f_addr[5:0], d_addr[5:0]};

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        resp_err_d  = resp_err_q;
        req_err_d   = req_err_q;
        f_gnt       = 1'b0;
        f_rvalid    = 1'b0;
        f_rlast     = 1'b0;
        d_gnt       = 1'b0;
        d_rvalid    = 1'b0;
        d_rlast     = 1'b0;
        d_wready    = 1'b0;
        r_data      = '0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        // Every response beat is acknowledged, even ones that get dropped
        bus_respack = bus_respcyc;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = port_e'(pick_idx);
                    if (pick_idx) begin
                        addr_d = {d_addr[DATA_W-1:6], 6'b0};
                        tag_d  = {(d_write ? TAG_WRITE : TAG_READ), TAG_MEMORY, 7'd0, 1'b1};
                    end else begin
                        addr_d = {f_addr[DATA_W-1:6], 6'b0};
                        tag_d  = {TAG_READ, TAG_MEMORY, 7'd0, 1'b0};
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                bus_reqtag = tag_q;
                if (!owner_req) begin
                    req_err_d = 1'b1;
                end
                if (bus_reqack) begin
                    f_gnt   = (owner_q == PORT_F);
                    d_gnt   = (owner_q == PORT_D);
                    last_d  = owner_q;
                    state_d = is_write ? WDATA : RESP;
                end
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = d_wdata;
                bus_reqtag = tag_q;
                d_wready   = bus_reqack;
                if (bus_reqack) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (bus_respcyc) begin
                    if (tag_match) begin
                        r_data   = bus_resp;
                        f_rvalid = (owner_q == PORT_F);
                        d_rvalid = (owner_q == PORT_D);
                        f_rlast  = (owner_q == PORT_F) && last_beat;
                        d_rlast  = (owner_q == PORT_D) && last_beat;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_d = IDLE;
                        end
                    end else begin
                        resp_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus_respcyc && (state_q != RESP)) begin
            resp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= PORT_D;
            owner_q    <= PORT_F;
            addr_q     <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
            req_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            resp_err_q <= resp_err_d;
            req_err_q  <= req_err_d;
        end
    end

endmodule
